jk_seq_driver: RTL and testbench
================================

JK_SEQ_DRIVER -- requirements
Module: jk_seq_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of external JK flip-flops driven.
REQ-002 SHALL have parameter USE_TOGGLE, default 0: encoding for changing bits. 0 means set/reset encoding; 1 means J=K=1 toggle encoding.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: request to move the external register to target.
REQ-006 SHALL have port target, input, WIDTH bits: destination value, sampled when start is accepted.
REQ-007 SHALL have port q_fb, input, WIDTH bits: feedback from the Q outputs of the external JK register.
REQ-008 SHALL have port j, output, WIDTH bits: per-bit J drive, registered.
REQ-009 SHALL have port k, output, WIDTH bits: per-bit K drive, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while a move is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on successful arrival at target.
REQ-012 SHALL have port err, output, 1 bit: sticky feedback-mismatch flag.

Function
REQ-013 SHALL implement FSM states IDLE, STEP, CHECK, DONE and ERR.
REQ-014 IDLE: start=1 SHALL latch target into tgt_r and assert busy on the next cycle.
REQ-015 IDLE with start=1 SHALL clear err.
REQ-016 IDLE with start=1 and target==q_fb SHALL go to DONE; otherwise it SHALL go to STEP.
REQ-017 STEP SHALL compute nxt = q_fb+1 if tgt_r>q_fb (unsigned), else q_fb-1, all modulo 2^WIDTH. Wrap-around SHALL never be used.
REQ-018 STEP SHALL drive j and k for exactly one cycle using the per-bit excitation table (q->nxt):
- 0->0: J=0, K=0
- 1->1: J=0, K=0
- 0->1: J=1, K=0, or J=K=1 if USE_TOGGLE
- 1->0: J=0, K=1, or J=K=1 if USE_TOGGLE
REQ-019 STEP SHALL hold nxt in exp_r and go to CHECK.
REQ-020 In every state other than STEP, j and k SHALL be 0, so the external register holds.
REQ-021 CHECK SHALL compare q_fb with exp_r. On mismatch it SHALL go to ERR. On match with exp_r==tgt_r it SHALL go to DONE. On match otherwise it SHALL go to STEP.
REQ-022 DONE SHALL assert done for one cycle, deassert busy and return to IDLE.
REQ-023 ERR SHALL set err=1, deassert busy and return to IDLE; err SHALL remain 1 until the next accepted start or reset.
REQ-024 The cost of a move SHALL be 2 cycles per unit of distance |tgt_r - q_fb_initial| plus 1 DONE cycle. done SHALL rise 2*d+1 cycles after the start cycle. For d=0, done SHALL rise the cycle after start.
REQ-025 start while busy SHALL be ignored, and target changes while busy SHALL be ignored.
REQ-026 At most one of done or err SHALL be asserted in any cycle.

Reset
REQ-027 While rst=0 at a clock edge, the block SHALL go to IDLE with j=0, k=0, busy=0, done=0, err=0 and tgt_r=0, exp_r=0.
REQ-028 Reset during STEP or CHECK SHALL abort the move with no further j/k pulses; the external register is left at its current value.

Structure
REQ-029 Shared package jk_pkg SHALL hold the FSM state enum and the 2-bit jk_t ({j,k}) type.
REQ-030 Combinational sub-module jk_excite SHALL map (q, nxt, USE_TOGGLE) to {j,k} for one bit. It SHALL be instantiated WIDTH times.

Verification
REQ-031 The bench SHALL use WIDTH instances of the team's JK flip-flop, with the same clk and rst, as the external register, feeding q_fb.
REQ-032 Scenario: reset, then start with target=5 from q=0 -> five j/k pulses, q steps 1,2,3,4,5, done 11 cycles after start, err=0.
REQ-033 Scenario: from q=5, start with target=2 -> bits decrement via K, q steps 4,3,2, done after 7 cycles.
REQ-034 Scenario: start with target equal to q -> no j/k activity, done the next cycle, busy high for 1 cycle.
REQ-035 Scenario: force one flip-flop stuck during a CHECK -> err=1, busy=0, no done; a new start clears err.
REQ-036 Scenario: rst=0 mid-move at q=3 toward 9, with USE_TOGGLE=1 -> j=k=0 next cycle and the FSM in IDLE. Note that a real JK flip-flop with active-low reset clears q to 0.
REQ-037 Scenario: start pulses and target changes while busy -> ignored, and the original move completes unchanged.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types for the JK sequence driver: FSM state encoding and the per-bit {j,k} drive pair.
package jk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

endpackage

// File: rtl/jk_excite.sv
// Single-bit JK excitation: picks the {j,k} pair that moves a JK flip-flop from q to nxt.
module jk_excite
  import jk_pkg::*;
#(
  parameter int USE_TOGGLE = 0
) (
  input  logic i_q,
  input  logic i_nxt,
  output jk_t  o_jk
);

  always_comb begin
    o_jk = '0;
    if (i_q != i_nxt) begin
      if (USE_TOGGLE != 0) begin
        o_jk.j = 1'b1;
        o_jk.k = 1'b1;
      end else if (i_nxt) begin
        o_jk.j = 1'b1;
      end else begin
        o_jk.k = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_ff.sv
// Plain JK flip-flop with synchronous active-low clear, used as the external register being driven.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_driver.sv
// Walks an external JK register one unit at a time toward a target, verifying each step via Q feedback.
module jk_seq_driver
  import jk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int USE_TOGGLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_exp;
  logic             r_err;
  logic [WIDTH-1:0] w_tgt_eff;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  jk_t              w_jk [WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (target == q_fb) ? S_DONE : S_STEP;
      S_STEP:  w_next = S_CHECK;
      S_CHECK: begin
        if (q_fb != r_exp)       w_next = S_ERR;
        else if (r_exp == r_tgt) w_next = S_DONE;
        else                     w_next = S_STEP;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_STEP) || (r_state == S_CHECK) || (r_state == S_DONE);
    done = (r_state == S_DONE);
    err  = r_err;
  end

  // The step is planned on the edge that enters STEP, so j/k are already driven
  // during STEP and the flip-flops land on nxt by the time CHECK samples q_fb.
  // Coming out of IDLE the target has not been latched yet, so use the port.
  always_comb begin
    w_tgt_eff = (r_state == S_IDLE) ? target : r_tgt;
    w_nxt     = (w_tgt_eff > q_fb) ? q_fb + WIDTH'(1) : q_fb - WIDTH'(1);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_exc
    jk_excite #(.USE_TOGGLE(USE_TOGGLE)) u_exc (
      .i_q   (q_fb[g]),
      .i_nxt (w_nxt[g]),
      .o_jk  (w_jk[g])
    );
    assign w_j[g] = w_jk[g].j;
    assign w_k[g] = w_jk[g].k;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      j     <= '0;
      k     <= '0;
      r_tgt <= '0;
      r_exp <= '0;
      r_err <= 1'b0;
    end else begin
      j <= '0;
      k <= '0;
      if (w_next == S_STEP) begin
        j     <= w_j;
        k     <= w_k;
        r_exp <= w_nxt;
      end
      if ((r_state == S_IDLE) && start) begin
        r_tgt <= target;
        r_err <= 1'b0;
      end
      if (w_next == S_ERR) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Directed bench: two drivers (set/reset and toggle encodings) each steering a real JK register.
module tb_jk_seq_driver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_n, start_t;
  logic [W-1:0] target_n, target_t;
  logic [W-1:0] q_n, q_t, qfb_n;
  logic [W-1:0] stuck_mask, stuck_val;
  logic [W-1:0] j_n, k_n, j_t, k_t;
  logic         busy_n, done_n, err_n, busy_t, done_t, err_t;

  logic         sel;
  logic [W-1:0] s_j, s_k, s_q;
  logic         s_busy, s_done, s_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign qfb_n = (q_n & ~stuck_mask) | (stuck_val & stuck_mask);

  jk_seq_driver #(.WIDTH(W), .USE_TOGGLE(0)) u_dut_n (
    .clk(clk), .rst(rst), .start(start_n), .target(target_n), .q_fb(qfb_n),
    .j(j_n), .k(k_n), .busy(busy_n), .done(done_n), .err(err_n)
  );

  jk_seq_driver #(.WIDTH(W), .USE_TOGGLE(1)) u_dut_t (
    .clk(clk), .rst(rst), .start(start_t), .target(target_t), .q_fb(q_t),
    .j(j_t), .k(k_t), .busy(busy_t), .done(done_t), .err(err_t)
  );

  for (genvar g = 0; g < W; g++) begin : g_reg
    jk_ff u_ff_n (.clk(clk), .rst(rst), .j(j_n[g]), .k(k_n[g]), .q(q_n[g]));
    jk_ff u_ff_t (.clk(clk), .rst(rst), .j(j_t[g]), .k(k_t[g]), .q(q_t[g]));
  end

  always_comb begin
    s_j    = sel ? j_t    : j_n;
    s_k    = sel ? k_t    : k_n;
    s_q    = sel ? q_t    : q_n;
    s_busy = sel ? busy_t : busy_n;
    s_done = sel ? done_t : done_n;
    s_err  = sel ? err_t  : err_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input bit tog, input logic s, input logic [W-1:0] tgt);
    if (tog) begin start_t = s; target_t = tgt; end
    else     begin start_n = s; target_n = tgt; end
  endtask

  // Moves the selected driver to tgt; with noise set, start/target are jabbed while busy.
  task automatic run_move(input bit tog, input logic [W-1:0] tgt, input int d,
                          input bit noise, input string tag);
    logic [W-1:0] qe, nx, ej, ek;
    int pulses, done_at, done_cnt;
    bit up;
    sel = tog;
    @(negedge clk);
    qe = s_q;
    up = (tgt > qe);
    pulses = 0; done_at = 0; done_cnt = 0;
    drive_start(tog, 1'b1, tgt);
    for (int n = 1; n <= 2 * d + 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk({tag, "_busy1"}, s_busy, 1);
        chk({tag, "_errclr"}, s_err, 0);
      end
      if (s_j != '0 || s_k != '0) begin
        pulses++;
        nx = up ? qe + 4'd1 : qe - 4'd1;
        if (tog) begin ej = qe ^ nx; ek = qe ^ nx; end
        else     begin ej = ~qe & nx; ek = qe & ~nx; end
        chk({tag, "_j"}, s_j, ej);
        chk({tag, "_k"}, s_k, ek);
        qe = nx;
      end else if (s_busy) begin
        chk({tag, "_qstep"}, s_q, qe);
      end
      if (s_done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (noise && n >= 2 && n <= 4) drive_start(tog, 1'b1, ~tgt);
      else                           drive_start(tog, 1'b0, ~tgt);
    end
    chk({tag, "_pulses"}, pulses, d);
    chk({tag, "_done_at"}, done_at, 2 * d + 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_qfinal"}, s_q, tgt);
    chk({tag, "_err"}, s_err, 0);
    chk({tag, "_idle"}, s_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    rst = 1'b0; sel = 1'b0;
    start_n = 1'b0; start_t = 1'b0; target_n = '0; target_t = '0;
    stuck_mask = '0; stuck_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_j", j_n, 0);
    chk("rst_k", k_n, 0);
    chk("rst_busy", busy_n, 0);
    chk("rst_done", done_n, 0);
    chk("rst_err", err_n, 0);
    chk("rst_q", q_n, 0);
    chk("rst_t_jk", {j_t, k_t}, 0);
    rst = 1'b1;
    @(negedge clk);

    run_move(0, 4'd5, 5, 0, "up5");
    run_move(0, 4'd2, 3, 0, "dn2");
    run_move(0, 4'd2, 0, 0, "eq");

    // Stuck bit 0 hides the 2->3 step from the driver.
    sel = 1'b0;
    @(negedge clk);
    drive_start(0, 1'b1, 4'd6);
    @(negedge clk);
    drive_start(0, 1'b0, 4'd6);
    stuck_mask = 4'b0001; stuck_val = 4'b0000;
    chk("stk_busy1", busy_n, 1);
    dn = 0;
    @(negedge clk);
    if (done_n) dn++;
    @(negedge clk);
    if (done_n) dn++;
    chk("stk_err", err_n, 1);
    chk("stk_busy", busy_n, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_n) dn++;
      chk("stk_sticky", err_n, 1);
      chk("stk_jk", {j_n, k_n}, 0);
    end
    chk("stk_nodone", dn, 0);
    chk("stk_qreal", q_n, 3);
    stuck_mask = '0;
    run_move(0, 4'd3, 0, 0, "clr");

    run_move(0, 4'd1, 2, 1, "ign");
    repeat (3) @(negedge clk);
    chk("ign_hold", q_n, 1);
    chk("ign_idle", busy_n, 0);

    run_move(1, 4'd3, 3, 0, "tog3");

    // Abort a toggle-mode move 3 -> 9 while its first pulse is on the wires.
    sel = 1'b1;
    @(negedge clk);
    drive_start(1, 1'b1, 4'd9);
    @(negedge clk);
    drive_start(1, 1'b0, 4'd9);
    chk("ab_jpulse", j_t, 4'b0111);
    chk("ab_kpulse", k_t, 4'b0111);
    rst = 1'b0;
    @(negedge clk);
    chk("ab_j", j_t, 0);
    chk("ab_k", k_t, 0);
    chk("ab_busy", busy_t, 0);
    chk("ab_done", done_t, 0);
    chk("ab_q", q_t, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ab_quiet", {j_t, k_t, busy_t}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
